// File: rtl/avmm_mem_tester.sv
`default_nettype none
// ---------------------------------------------------------------------------
// avmm_mem_tester : Avalon-MM master for CSR-issued bursts and a memory
// address-pattern self-test with pipelined, bounded readback.   Rev 1.0
// ---------------------------------------------------------------------------
module avmm_mem_tester #(
  parameter int DATA_W          = 64,
  parameter int ADDR_W          = 32,
  parameter int BURST_W         = 7,
  parameter int TEST_ADDR_BITS  = 6,
  parameter int MAX_OUTSTANDING = 8,
  parameter int USE_WRRESP      = 0
) (
  input  logic                      pClk,
  input  logic                      pck_cp2af_softReset_n,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_op,
  input  logic [ADDR_W-1:0]         cmd_address,
  input  logic [BURST_W-1:0]        cmd_burstcount,
  input  logic [DATA_W-1:0]         cmd_writedata,
  output logic [ADDR_W-1:0]         avs_address,
  output logic [BURST_W-1:0]        avs_burstcount,
  output logic [DATA_W-1:0]         avs_writedata,
  output logic [DATA_W/8-1:0]       avs_byteenable,
  output logic                      avs_write,
  output logic                      avs_read,
  input  logic                      avs_waitrequest,
  input  logic                      avs_readdatavalid,
  input  logic                      avs_writeresponsevalid,
  input  logic [DATA_W-1:0]         avs_readdata,
  input  logic [1:0]                avs_response,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic                      done,
  input  logic                      status_clear,
  output logic                      err_resp,
  output logic                      err_cmd,
  output logic                      test_fail,
  output logic [15:0]               test_err_count,
  output logic [TEST_ADDR_BITS-1:0] test_first_fail_addr
);

  localparam int c_out_w = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [c_out_w-1:0]        c_out_one  = c_out_w'(1);
  localparam logic [c_out_w-1:0]        c_out_max  = c_out_w'(MAX_OUTSTANDING);
  localparam logic [BURST_W-1:0]        c_beat_one = BURST_W'(1);
  localparam logic [DATA_W-1:0]         c_data_one = DATA_W'(1);
  localparam logic [TEST_ADDR_BITS-1:0] c_at_one   = TEST_ADDR_BITS'(1);
  localparam logic [TEST_ADDR_BITS-1:0] c_at_last  = '1;
  localparam logic [15:0]               c_cnt_max  = 16'hFFFF;

  typedef enum logic [3:0] {
    IDLE, WR, WR_RSP, RD_CMD, RD_DATA, AT_WR, AT_RD, AT_DRAIN, DONE
  } state_t;

  state_t                    r_state;
  logic [BURST_W-1:0]        r_bcnt;
  logic [BURST_W-1:0]        r_beat;
  logic [TEST_ADDR_BITS-1:0] r_at;
  logic [TEST_ADDR_BITS-1:0] r_exp;
  logic [c_out_w-1:0]        r_out;

  logic                      w_wr_acc;
  logic                      w_rd_acc;
  logic                      w_at_rd_acc;
  logic                      w_at_rdv;
  logic                      w_illegal;
  logic                      w_resp_err;
  logic [TEST_ADDR_BITS-1:0] w_at_next;
  logic [c_out_w-1:0]        w_out_next;

  assign avs_byteenable = '1;
  assign w_wr_acc    = avs_write & ~avs_waitrequest;
  assign w_rd_acc    = avs_read & ~avs_waitrequest;
  assign w_at_rd_acc = w_rd_acc & (r_state == AT_RD);
  assign w_at_rdv    = avs_readdatavalid & ((r_state == AT_RD) | (r_state == AT_DRAIN));
  assign w_illegal   = (cmd_op == 2'd3) | (cmd_burstcount == '0);
  assign w_resp_err  = |avs_response;
  assign w_at_next   = r_at + c_at_one;

  // Issue and return in the same cycle leave the in-flight count unchanged.
  always_comb begin
    w_out_next = r_out;
    if (w_at_rd_acc && !w_at_rdv)      w_out_next = r_out + c_out_one;
    else if (!w_at_rd_acc && w_at_rdv) w_out_next = r_out - c_out_one;
  end

  always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
    if (!pck_cp2af_softReset_n) begin
      r_state              <= IDLE;
      cmd_ready            <= 1'b1;
      avs_address          <= '0;
      avs_burstcount       <= '0;
      avs_writedata        <= '0;
      avs_write            <= 1'b0;
      avs_read             <= 1'b0;
      rd_data              <= '0;
      rd_valid             <= 1'b0;
      done                 <= 1'b0;
      err_resp             <= 1'b0;
      err_cmd              <= 1'b0;
      test_fail            <= 1'b0;
      test_err_count       <= '0;
      test_first_fail_addr <= '0;
      r_bcnt               <= '0;
      r_beat               <= '0;
      r_at                 <= '0;
      r_exp                <= '0;
      r_out                <= '0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      r_out    <= w_out_next;

      if (r_state == IDLE && status_clear) begin
        err_resp             <= 1'b0;
        err_cmd              <= 1'b0;
        test_fail            <= 1'b0;
        test_err_count       <= '0;
        test_first_fail_addr <= '0;
      end

      // Self-test readback: returns arrive in issue order, so a counter is the expected data.
      if (w_at_rdv) begin
        r_exp <= r_exp + c_at_one;
        if (w_resp_err) err_resp <= 1'b1;
        if (avs_readdata != DATA_W'(r_exp)) begin
          test_fail <= 1'b1;
          if (test_err_count != c_cnt_max) test_err_count <= test_err_count + 16'd1;
          if (!test_fail) test_first_fail_addr <= r_exp;
        end
      end

      case (r_state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            r_bcnt    <= cmd_burstcount;
            r_beat    <= '0;
            if (w_illegal) begin
              err_cmd <= 1'b1;
              done    <= 1'b1;
              r_state <= DONE;
            end else if (cmd_op == 2'd0) begin
              avs_write      <= 1'b1;
              avs_address    <= cmd_address;
              avs_burstcount <= cmd_burstcount;
              avs_writedata  <= cmd_writedata;
              r_state        <= WR;
            end else if (cmd_op == 2'd1) begin
              avs_read       <= 1'b1;
              avs_address    <= cmd_address;
              avs_burstcount <= cmd_burstcount;
              r_state        <= RD_CMD;
            end else begin
              avs_write      <= 1'b1;
              avs_address    <= '0;
              avs_burstcount <= c_beat_one;
              avs_writedata  <= '0;
              r_at           <= '0;
              r_exp          <= '0;
              r_out          <= '0;
              r_state        <= AT_WR;
            end
          end
        end
        WR: begin
          if (w_wr_acc) begin
            if (r_beat == r_bcnt - c_beat_one) begin
              avs_write <= 1'b0;
              if (USE_WRRESP != 0) begin
                r_state <= WR_RSP;
              end else begin
                done    <= 1'b1;
                r_state <= DONE;
              end
            end else begin
              r_beat        <= r_beat + c_beat_one;
              avs_writedata <= avs_writedata + c_data_one;
            end
          end
        end
        WR_RSP: begin
          if (avs_writeresponsevalid) begin
            if (w_resp_err) err_resp <= 1'b1;
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        RD_CMD: begin
          if (w_rd_acc) begin
            avs_read <= 1'b0;
            r_state  <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (avs_readdatavalid) begin
            rd_data  <= avs_readdata;
            rd_valid <= 1'b1;
            if (w_resp_err) err_resp <= 1'b1;
            if (r_beat == r_bcnt - c_beat_one) begin
              done    <= 1'b1;
              r_state <= DONE;
            end else begin
              r_beat <= r_beat + c_beat_one;
            end
          end
        end
        AT_WR: begin
          if (w_wr_acc) begin
            if (r_at == c_at_last) begin
              avs_write   <= 1'b0;
              avs_read    <= 1'b1;
              avs_address <= '0;
              r_at        <= '0;
              r_state     <= AT_RD;
            end else begin
              r_at          <= w_at_next;
              avs_address   <= ADDR_W'(w_at_next);
              avs_writedata <= DATA_W'(w_at_next);
            end
          end
        end
        AT_RD: begin
          // A stalled request stays up; a throttled one re-arms once a slot frees.
          if (w_rd_acc) begin
            if (r_at == c_at_last) begin
              avs_read <= 1'b0;
              r_state  <= AT_DRAIN;
            end else begin
              r_at        <= w_at_next;
              avs_address <= ADDR_W'(w_at_next);
              avs_read    <= (w_out_next < c_out_max);
            end
          end else if (!avs_read) begin
            avs_read <= (w_out_next < c_out_max);
          end
        end
        AT_DRAIN: begin
          if (w_out_next == '0) begin
            done    <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          cmd_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_avmm_mem_tester.sv
`default_nettype none
// tb_avmm_mem_tester : directed bench with a small Avalon memory slave model.
module tb_avmm_mem_tester;
  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BW = 7;
  localparam int TB = 6;

  logic pClk = 1'b0;
  logic rst_n = 1'b0;
  always #5 pClk = ~pClk;

  logic           cmd_valid = 1'b0, cmd_valid_r = 1'b0;
  logic [1:0]     cmd_op = '0;
  logic [AW-1:0]  cmd_address = '0;
  logic [BW-1:0]  cmd_burstcount = '0;
  logic [DW-1:0]  cmd_writedata = '0;
  logic           status_clear = 1'b0;
  logic           avs_waitrequest = 1'b0, avs_readdatavalid = 1'b0;
  logic [DW-1:0]  avs_readdata = '0;
  logic [1:0]     avs_response = '0;
  logic           wresp_valid_r = 1'b0;
  logic [1:0]     resp_r = '0;

  logic           cmd_ready, avs_write, avs_read, rd_valid, done, err_resp, err_cmd, test_fail;
  logic [AW-1:0]  avs_address;
  logic [BW-1:0]  avs_burstcount;
  logic [DW-1:0]  avs_writedata, rd_data;
  logic [DW/8-1:0] avs_byteenable;
  logic [15:0]    test_err_count;
  logic [TB-1:0]  test_first_fail_addr;

  logic           cmd_ready_r, avs_write_r, avs_read_r, rd_valid_r, done_r, err_resp_r, err_cmd_r, test_fail_r;
  logic [AW-1:0]  avs_address_r;
  logic [BW-1:0]  avs_burstcount_r;
  logic [DW-1:0]  avs_writedata_r, rd_data_r;
  logic [DW/8-1:0] avs_byteenable_r;
  logic [15:0]    test_err_count_r;
  logic [TB-1:0]  test_first_fail_addr_r;

  avmm_mem_tester #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .TEST_ADDR_BITS(TB),
                    .MAX_OUTSTANDING(8), .USE_WRRESP(0)) dut (
    .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_address(cmd_address),
    .cmd_burstcount(cmd_burstcount), .cmd_writedata(cmd_writedata),
    .avs_address(avs_address), .avs_burstcount(avs_burstcount), .avs_writedata(avs_writedata),
    .avs_byteenable(avs_byteenable), .avs_write(avs_write), .avs_read(avs_read),
    .avs_waitrequest(avs_waitrequest), .avs_readdatavalid(avs_readdatavalid),
    .avs_writeresponsevalid(1'b0), .avs_readdata(avs_readdata), .avs_response(avs_response),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .status_clear(status_clear),
    .err_resp(err_resp), .err_cmd(err_cmd), .test_fail(test_fail),
    .test_err_count(test_err_count), .test_first_fail_addr(test_first_fail_addr));

  avmm_mem_tester #(.DATA_W(DW), .ADDR_W(AW), .BURST_W(BW), .TEST_ADDR_BITS(TB),
                    .MAX_OUTSTANDING(8), .USE_WRRESP(1)) dut_r (
    .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
    .cmd_valid(cmd_valid_r), .cmd_ready(cmd_ready_r), .cmd_op(cmd_op), .cmd_address(cmd_address),
    .cmd_burstcount(cmd_burstcount), .cmd_writedata(cmd_writedata),
    .avs_address(avs_address_r), .avs_burstcount(avs_burstcount_r), .avs_writedata(avs_writedata_r),
    .avs_byteenable(avs_byteenable_r), .avs_write(avs_write_r), .avs_read(avs_read_r),
    .avs_waitrequest(1'b0), .avs_readdatavalid(1'b0),
    .avs_writeresponsevalid(wresp_valid_r), .avs_readdata({DW{1'b0}}), .avs_response(resp_r),
    .rd_data(rd_data_r), .rd_valid(rd_valid_r), .done(done_r), .status_clear(status_clear),
    .err_resp(err_resp_r), .err_cmd(err_cmd_r), .test_fail(test_fail_r),
    .test_err_count(test_err_count_r), .test_first_fail_addr(test_first_fail_addr_r));

  // ---------------- slave model and observers ----------------
  typedef struct { logic [5:0] a; int due; } rd_t;
  logic [DW-1:0] mem [64];
  rd_t           rq[$];
  int  cyc = 0, last_due = 0, lat = 1;
  bit  rand_wait = 0, rand_lat = 0, fault = 0;
  int  n_rd_acc = 0, act = 0, out_m = 0, max_out = 0, done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  int  first_rd_cyc = 0, last_rd_cyc = 0, done_cnt_r = 0, n_wr_r = 0;
  logic [AW-1:0] wl_a[$];
  logic [BW-1:0] wl_b[$];
  logic [DW-1:0] wl_d[$];
  int            wl_c[$];
  logic [DW-1:0] rv_d[$];
  int            rv_c[$];
  int            rdv_c[$];
  logic [AW-1:0] ra_a = '0;
  logic [BW-1:0] ra_b = '0;

  always @(posedge pClk) begin
    int d;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (avs_write || avs_read) act++;
    if (avs_write && !avs_waitrequest) begin
      mem[avs_address[5:0]] = avs_writedata;
      wl_a.push_back(avs_address); wl_b.push_back(avs_burstcount);
      wl_d.push_back(avs_writedata); wl_c.push_back(cyc);
    end
    if (avs_read && !avs_waitrequest) begin
      ra_a = avs_address; ra_b = avs_burstcount;
      if (n_rd_acc == 0) first_rd_cyc = cyc;
      last_rd_cyc = cyc; n_rd_acc++; out_m++;
      for (int i = 0; i < int'(avs_burstcount); i++) begin
        d = cyc + lat + (rand_lat ? int'($urandom_range(0, 3)) : 0);
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        rq.push_back('{a: avs_address[5:0] + 6'(i), due: d});
      end
    end
    if (avs_readdatavalid) begin out_m--; rdv_c.push_back(cyc); end
    if (out_m > max_out) max_out = out_m;
    if (rd_valid) begin rv_d.push_back(rd_data); rv_c.push_back(cyc); end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (done_r) done_cnt_r++;
    if (avs_write_r) n_wr_r++;
    cyc++;
  end

  always @(negedge pClk) begin
    avs_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      avs_readdatavalid = 1'b1;
      avs_readdata = mem[rq[0].a] | ((fault && rq[0].a == 6'd5) ? 64'h8 : 64'h0);
      void'(rq.pop_front());
    end else begin
      avs_readdatavalid = 1'b0;
    end
  end

  // ---------------- checking ----------------
  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wl_a.delete(); wl_b.delete(); wl_d.delete(); wl_c.delete();
    rv_d.delete(); rv_c.delete(); rdv_c.delete();
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [AW-1:0] a,
                           input logic [BW-1:0] bc, input logic [DW-1:0] wd);
    @(negedge pClk);
    cmd_op = op; cmd_address = a; cmd_burstcount = bc; cmd_writedata = wd; cmd_valid = 1'b1;
    @(negedge pClk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < lim) begin @(negedge pClk); n++; end
    check({tag, " done"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic pulse_clear();
    @(negedge pClk); status_clear = 1'b1;
    @(negedge pClk); status_clear = 1'b0;
  endtask

  task automatic run_selftest(input string tag);
    out_m = 0; max_out = 0; n_rd_acc = 0;
    clear_logs();
    start_cmd(2'd2, '0, 7'd1, '0);
    wait_done(tag, 4000);
  endtask

  initial begin
    int errs, act0;
    for (int i = 0; i < 64; i++) mem[i] = '0;
    repeat (3) @(negedge pClk);
    check("rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst avs_write", 64'(avs_write), 64'd0);
    check("rst avs_read", 64'(avs_read), 64'd0);
    check("rst byteenable", 64'(avs_byteenable), 64'hFF);
    check("rst done", 64'(done), 64'd0);
    check("rst sticky", 64'({err_resp, err_cmd, test_fail, test_err_count}), 64'd0);
    rst_n = 1'b1;
    @(negedge pClk);

    // Four-beat write burst, zero-wait slave
    clear_logs(); act0 = act;
    start_cmd(2'd0, 32'h100, 7'd4, 64'h10);
    wait_done("wr4", 50);
    check("wr4 beats", 64'(wl_d.size()), 64'd4);
    check("wr4 write cycles", 64'(act - act0), 64'd4);
    for (int i = 0; i < wl_d.size(); i++) begin
      check("wr4 data", wl_d[i], 64'h10 + 64'(i));
      check("wr4 addr", 64'(wl_a[i]), 64'h100);
      check("wr4 burstcount", 64'(wl_b[i]), 64'd4);
    end
    if (wl_c.size() == 4) begin
      check("wr4 first beat latency", 64'(wl_c[0] - acc_cyc), 64'd1);
      check("wr4 done latency", 64'(done_cyc - wl_c[3]), 64'd1);
    end

    // Seed wrap-around
    clear_logs();
    start_cmd(2'd0, 32'h200, 7'd2, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_done("wrap", 50);
    check("wrap beats", 64'(wl_d.size()), 64'd2);
    if (wl_d.size() == 2) begin
      check("wrap beat0", wl_d[0], 64'hFFFF_FFFF_FFFF_FFFF);
      check("wrap beat1", wl_d[1], 64'h0);
    end

    // Three-beat read with random stalls and latency
    mem[32] = 64'hA; mem[33] = 64'hB; mem[34] = 64'hC;
    clear_logs(); rand_wait = 1; rand_lat = 1;
    start_cmd(2'd1, 32'h20, 7'd3, '0);
    wait_done("rd3", 300);
    rand_wait = 0; rand_lat = 0;
    check("rd3 addr", 64'(ra_a), 64'h20);
    check("rd3 burstcount", 64'(ra_b), 64'd3);
    check("rd3 beats", 64'(rv_d.size()), 64'd3);
    if (rv_d.size() == 3 && rdv_c.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("rd3 data", rv_d[i], 64'hA + 64'(i));
        check("rd3 rd_valid lag", 64'(rv_c[i] - rdv_c[i]), 64'd1);
      end
      check("rd3 done with last beat", 64'(done_cyc - rv_c[2]), 64'd0);
    end
    check("rd3 err_resp", 64'(err_resp), 64'd0);

    // Self-test, ideal memory, 1-cycle latency
    lat = 1;
    run_selftest("at ideal");
    check("at writes", 64'(wl_d.size()), 64'd64);
    errs = 0;
    for (int i = 0; i < wl_d.size(); i++)
      if (wl_a[i] != AW'(i) || wl_d[i] != DW'(i) || wl_b[i] != 7'd1) errs++;
    check("at write pattern", 64'(errs), 64'd0);
    check("at reads", 64'(n_rd_acc), 64'd64);
    check("at one read per cycle", 64'(last_rd_cyc - first_rd_cyc), 64'd63);
    check("at test_fail", 64'(test_fail), 64'd0);
    check("at err_count", 64'(test_err_count), 64'd0);

    // Self-test with long latency: in-flight reads capped at 8
    lat = 20;
    run_selftest("at lat20");
    lat = 1;
    check("lat20 max outstanding", 64'(max_out), 64'd8);
    check("lat20 reads", 64'(n_rd_acc), 64'd64);
    check("lat20 test_fail", 64'(test_fail), 64'd0);

    // Stuck bit 3 at address 5
    fault = 1;
    run_selftest("at stuck");
    fault = 0;
    check("stuck test_fail", 64'(test_fail), 64'd1);
    check("stuck first addr", 64'(test_first_fail_addr), 64'd5);
    check("stuck err_count", 64'(test_err_count), 64'd1);
    pulse_clear();
    check("clear sticky", 64'({test_fail, test_err_count, test_first_fail_addr}), 64'd0);

    // Illegal commands: no bus activity
    act0 = act;
    start_cmd(2'd3, 32'h40, 7'd2, '0);
    wait_done("op3", 20);
    check("op3 err_cmd", 64'(err_cmd), 64'd1);
    pulse_clear();
    check("op3 cleared", 64'(err_cmd), 64'd0);
    start_cmd(2'd0, 32'h40, 7'd0, 64'd5);
    wait_done("bc0", 20);
    check("bc0 err_cmd", 64'(err_cmd), 64'd1);
    check("illegal no bus activity", 64'(act - act0), 64'd0);
    pulse_clear();

    // Write response path on the USE_WRRESP instance
    @(negedge pClk);
    cmd_op = 2'd0; cmd_address = 32'h300; cmd_burstcount = 7'd2; cmd_writedata = 64'd7;
    cmd_valid_r = 1'b1;
    @(negedge pClk); cmd_valid_r = 1'b0;
    repeat (5) @(negedge pClk);
    check("wrrsp beats", 64'(n_wr_r), 64'd2);
    check("wrrsp waiting", 64'({done_cnt_r != 0, cmd_ready_r}), 64'd0);
    resp_r = 2'b10; wresp_valid_r = 1'b1;
    @(negedge pClk); wresp_valid_r = 1'b0; resp_r = 2'b00;
    check("wrrsp done", 64'(done_r), 64'd1);
    check("wrrsp err_resp", 64'(err_resp_r), 64'd1);
    @(negedge pClk);
    check("wrrsp cmd_ready back", 64'(cmd_ready_r), 64'd1);

    // Reset during beat 2 of a write burst
    clear_logs();
    start_cmd(2'd0, 32'h80, 7'd4, 64'd1);
    @(posedge pClk); #2;
    check("mid beat2 data", avs_writedata, 64'd2);
    rst_n = 1'b0; #1;
    check("mid avs_write async drop", 64'(avs_write), 64'd0);
    check("mid cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge pClk); rst_n = 1'b1;
    @(negedge pClk);
    check("post rst cmd_ready", 64'(cmd_ready), 64'd1);
    check("post rst avs_write", 64'(avs_write), 64'd0);
    clear_logs();
    start_cmd(2'd0, 32'h10, 7'd1, 64'd9);
    wait_done("post rst wr", 50);
    check("post rst beats", 64'(wl_d.size()), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/avmm_mem_tester.md
# avmm_mem_tester

Parametrised Avalon-MM master engine that runs CSR-issued single/burst writes and reads and a built-in address-pattern self-test against the local memory port. It sits between the AFU CSR block and the memory-side Avalon-MM slave. It generalises data/address/burst widths, pipelines self-test reads with a bounded outstanding count, checks readback, and reports sticky error status with a first-failing address.

## Interface
- DATA_W, 64: Avalon data width (multiple of 8).
- ADDR_W, 32: Avalon word-address width.
- BURST_W, 7: burstcount width; max burst 2^(BURST_W-1).
- TEST_ADDR_BITS, 6: self-test covers word addresses 0 .. 2^TEST_ADDR_BITS-1.
- MAX_OUTSTANDING, 8: max in-flight self-test read beats (power of 2, ≥1).
- USE_WRRESP, 0: 1 = wait for avs_writeresponsevalid after each write burst.
- pClk  in  1  core clock; all logic is synchronous to it.
- pck_cp2af_softReset_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  0 write, 1 read, 2 address self-test, 3 reserved.
- cmd_address  in  ADDR_W  burst start word address.
- cmd_burstcount  in  BURST_W  beats per burst.
- cmd_writedata  in  DATA_W  write seed; beat i carries cmd_writedata + i (mod 2^DATA_W).
- avs_address / avs_burstcount / avs_writedata  out  ADDR_W / BURST_W / DATA_W  Avalon master.
- avs_byteenable  out  DATA_W/8  all ones.
- avs_write, avs_read  out  1  Avalon requests.
- avs_waitrequest, avs_readdatavalid, avs_writeresponsevalid  in  1  Avalon slave handshakes.
- avs_readdata  in  DATA_W;  avs_response  in  2.
- rd_data  out  DATA_W  read beat to CSR side; rd_valid  out  1  one pulse per beat (read op only).
- done  out  1  one-cycle pulse at command completion.
- status_clear  in  1  clears sticky status; ignored unless IDLE.
- err_resp  out  1  sticky: any non-zero avs_response seen.
- err_cmd  out  1  sticky: illegal command (op 3 or burstcount 0).
- test_fail  out  1  sticky: self-test mismatch; test_err_count  out  16  saturating mismatch count.
- test_first_fail_addr  out  TEST_ADDR_BITS  address of first mismatch.

## Operation
- States: IDLE, WR, WR_RSP, RD_CMD, RD_DATA, AT_WR, AT_RD, AT_DRAIN, DONE.
- IDLE: cmd accepted on cmd_valid & cmd_ready; command fields registered. Illegal command → DONE, err_cmd set, no bus activity.
- WR: avs_write high, avs_address/avs_burstcount held for the whole burst; beat advances on avs_write & ~avs_waitrequest. After last beat → WR_RSP if USE_WRRESP else DONE.
- WR_RSP: wait avs_writeresponsevalid, OR avs_response into err_resp, → DONE.
- RD_CMD: avs_read high until ~avs_waitrequest, → RD_DATA. RD_DATA: each avs_readdatavalid drives rd_data/rd_valid next cycle and ORs avs_response into err_resp; after burstcount beats → DONE.
- AT_WR: single-beat writes, address a = 0..N-1, data = zero-extended a; after beat N-1 accepted → AT_RD.
- AT_RD: single-beat reads a = 0..N-1; issue only while outstanding < MAX_OUTSTANDING; outstanding +1 on accepted read, −1 on readdatavalid, both same cycle = unchanged. After last read accepted → AT_DRAIN.
- Readback compare (AT_RD/AT_DRAIN): expected counter starts 0, +1 per return; mismatch → test_fail, test_err_count +1 (saturate 0xFFFF), first_fail_addr captured only when test_fail was 0.
- AT_DRAIN: outstanding == 0 → DONE. DONE: done pulse, → IDLE.
- status_clear in IDLE clears err_resp, err_cmd, test_fail, test_err_count, test_first_fail_addr; same-cycle new error wins over clear.
- readdatavalid outside RD_DATA/AT_RD/AT_DRAIN is ignored.

## Timing
- Reset: all outputs 0 except cmd_ready = 1, avs_byteenable all ones; state IDLE; asserted mid-burst aborts immediately, avs_write/avs_read drop asynchronously.
- First avs_write/avs_read assert the cycle after cmd acceptance.
- Avalon master outputs are registered; held stable while avs_waitrequest is high.
- rd_valid lags avs_readdatavalid by exactly 1 cycle.
- done asserts the cycle after final event (last write beat accepted, write response, last read beat, or drain empty); cmd_ready returns the cycle after done.
- Zero-wait slave: write burst of B beats takes B cycles of avs_write; self-test with N=64, fixed 1-cycle read latency, MAX_OUTSTANDING=8 issues one read per cycle.

## Test plan
- Write op, address 0x100, burstcount 4, seed 0x10, no waitrequest → 4 beats data 0x10..0x13, address/burstcount stable, done 1 cycle after beat 4.
- Read op, burstcount 3, slave returns 0xA,0xB,0xC with random waitrequest/latency → rd_valid three times with 0xA,0xB,0xC, done after third, err_resp 0.
- Self-test, ideal memory, TEST_ADDR_BITS=6 → 64 writes, 64 reads, test_fail 0, err_count 0; slave latency 20 cycles → outstanding never exceeds 8.
- Self-test with slave stuck bit 3 on address 5 data → test_fail 1, first_fail_addr 5, err_count 1; status_clear in IDLE → all zero.
- cmd_op 3 or burstcount 0 → no avs_write/avs_read, err_cmd 1, done pulse.
- Reset asserted during write burst beat 2 → avs_write 0 immediately, state IDLE, cmd_ready 1 after release; USE_WRRESP=1 with response 2'b10 → err_resp 1.
